// File: rtl/seg7_pkg.sv
// Shared types and glyph constants for the multiplexed seven-segment display blocks.
// Glyphs are active-low {g,f,e,d,c,b,a}; SEG_BLANK turns every segment off.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);
  localparam int DATA_W     = 4 * NUM_DIGITS;

  typedef logic [NUM_DIGITS-1:0] an_t;
  typedef logic [IDX_W-1:0]      idx_t;
  typedef logic [6:0]            glyph_t;

  typedef logic [0:0] state_t;
  localparam state_t BLANK = 1'b0;
  localparam state_t SCAN  = 1'b1;

  localparam glyph_t SEG_BLANK = 7'b1111111;
  localparam glyph_t SEG_0     = 7'b1000000;
  localparam glyph_t SEG_1     = 7'b1111001;
  localparam glyph_t SEG_2     = 7'b0100100;
  localparam glyph_t SEG_3     = 7'b0110000;
  localparam glyph_t SEG_4     = 7'b0011001;
  localparam glyph_t SEG_5     = 7'b0010010;
  localparam glyph_t SEG_6     = 7'b0000010;
  localparam glyph_t SEG_7     = 7'b1111000;
  localparam glyph_t SEG_8     = 7'b0000000;
  localparam glyph_t SEG_9     = 7'b0010000;
  localparam glyph_t SEG_A     = 7'b0001000;
  localparam glyph_t SEG_B     = 7'b0000011;
  localparam glyph_t SEG_C     = 7'b1000110;
  localparam glyph_t SEG_D     = 7'b0100001;
  localparam glyph_t SEG_E     = 7'b0000110;
  localparam glyph_t SEG_F     = 7'b0001110;

  // One frame's worth of inputs, captured together so a frame never tears.
  typedef struct packed {
    logic [DATA_W-1:0]     time_display;
    logic                  blank_lz;
    logic [NUM_DIGITS-1:0] dp_sel;
  } snap_t;

  // True when digit k is a leading zero: k > 0 and nibbles top..k are all zero.
  function automatic logic lead_zero(input logic [DATA_W-1:0] v, input idx_t k);
    logic z;
    z = (k != '0);
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (i >= int'(k) && v[i*4 +: 4] != 4'h0) z = 1'b0;
    end
    return z;
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Display-side bundle: value/blanking/dp inputs from the timing logic and the pin outputs.
// master drives the value and observes the pins; slave is the scan driver.
interface seg7_scan_if;
  import seg7_pkg::*;

  logic [DATA_W-1:0]     time_display;
  logic                  blank_lz;
  logic [NUM_DIGITS-1:0] dp_sel;
  an_t                   an;
  glyph_t                seg;
  logic                  dp;
  logic                  frame_start;

  modport master (
    output time_display, blank_lz, dp_sel,
    input  an, seg, dp, frame_start
  );

  modport slave (
    input  time_display, blank_lz, dp_sel,
    output an, seg, dp, frame_start
  );
endinterface

// File: rtl/seg7_decode.sv
// Nibble to active-low hex glyph, purely combinational; no handshake.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output glyph_t     seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed 4-digit seven-segment scanner; outputs registered, first digit DIGIT_CYCLES edges after reset.
// Inputs snapshotted once per frame (0..4*DIGIT_CYCLES latency); no backpressure, display free-runs.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50_000
)
(
  input  logic        clk,
  input  logic        rst,
  seg7_scan_if.slave  io
);

  localparam int               CNT_W   = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGIT_CYCLES - 1);
  localparam idx_t             IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  state_t           state_q, state_d;
  idx_t             idx_q, idx_d;
  snap_t            snap_q, snap_d;
  logic             frame_load;

  logic [3:0]       nib;
  glyph_t           glyph;
  logic             blank_digit;

  an_t              an_q;
  glyph_t           seg_q;
  logic             dp_q;
  logic             frame_start_q;

  assign tick = (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Next-state values feed the output registers so the outputs move on the same edge as idx.
  always_comb begin
    frame_load = tick && ((state_q == BLANK) || (idx_q == IDX_MAX));
    state_d    = tick ? SCAN : state_q;
    idx_d      = idx_q;
    if (tick) idx_d = frame_load ? '0 : idx_q + IDX_W'(1);
    snap_d     = snap_q;
    if (frame_load) begin
      snap_d = '{time_display: io.time_display,
                 blank_lz:     io.blank_lz,
                 dp_sel:       io.dp_sel};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BLANK;
      idx_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  assign nib         = snap_d.time_display[{idx_d, 2'b00} +: 4];
  assign blank_digit = snap_d.blank_lz && lead_zero(snap_d.time_display, idx_d);

  seg7_decode u_decode (
    .nib (nib),
    .seg (glyph)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q          <= '1;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_load;
      if (tick) begin
        an_q  <= ~(an_t'(1) << idx_d);
        seg_q <= blank_digit ? SEG_BLANK : glyph;
        dp_q  <= ~snap_d.dp_sel[idx_d];
      end
    end
  end

  assign io.an          = an_q;
  assign io.seg         = seg_q;
  assign io.dp          = dp_q;
  assign io.frame_start = frame_start_q;

endmodule
